store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, is the number of buffered stores and SHALL be a power of two that is at least 2.
REQ-002 Parameter EXT_WIDTH, default 32, is the width of the address and external data buses.
REQ-003 Parameter DATA_WIDTH, default 8, is the width of one stored byte.
REQ-004 clk  in  1  is the single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  is the reset: asynchronous and active-low.
REQ-006 st_valid  in  1  signals a byte-store request from the memory stage.
REQ-007 st_addr  in  EXT_WIDTH  is the store byte address.
REQ-008 st_data  in  EXT_WIDTH  is the store data; only bits [7:0] are used.
REQ-009 st_ready  out  1  signals that the buffer can accept a store this cycle.
REQ-010 ld_valid  in  1  signals a byte-load request from the memory stage.
REQ-011 ld_addr  in  EXT_WIDTH  is the load byte address.
REQ-012 ld_data  out  EXT_WIDTH  is the load result, zero-extended byte.
REQ-013 ld_stall  out  1  signals that the load was not serviced and must be held.
REQ-014 mem_A  out  EXT_WIDTH  drives the data-memory address.
REQ-015 mem_WD  out  EXT_WIDTH  drives the data-memory write data.
REQ-016 mem_WE  out  1  drives the data-memory write enable.
REQ-017 mem_RD  in  EXT_WIDTH  is the data-memory read data (combinational read, low byte valid).
REQ-018 empty  out  1  is high when no stores are pending.

Function
REQ-019 The buffer SHALL be a circular FIFO of DEPTH entries, each holding an address, a data byte and a valid bit, managed by head and tail pointers that wrap modulo DEPTH plus an occupancy count of width clog2(DEPTH)+1.
REQ-020 st_ready SHALL be high exactly when count < DEPTH; there is no same-cycle bypass when full.
REQ-021 A store SHALL be enqueued when st_valid && st_ready: tail advances, and count increments unless a drain occurs in the same cycle.
REQ-022 A drain SHALL occur in a cycle when count > 0 && (!ld_valid || count == DEPTH): mem_WE=1, mem_A=head address, mem_WD={24'b0, head byte}; head advances and the entry is invalidated at the edge.
REQ-023 A store enqueued in cycle N SHALL NOT drain before cycle N+1.
REQ-024 In non-drain cycles the block SHALL drive mem_WE=0, mem_A=ld_addr and mem_WD=0.
REQ-025 A load in a non-drain cycle SHALL be serviced with ld_stall=0.
REQ-026 If any valid entry's address equals ld_addr, ld_data SHALL be the zero-extended byte of the youngest matching entry (closest to tail); otherwise ld_data = {24'b0, mem_RD[7:0]}.
REQ-027 A store presented in the same cycle as a load SHALL NOT be forwarded to that load.
REQ-028 When ld_valid && count == DEPTH, the drain has priority: ld_stall=1, ld_data=0, and the load is retried by the memory stage next cycle.
REQ-029 With ld_valid low, ld_stall SHALL be 0 and ld_data SHALL be 0.
REQ-030 Simultaneous enqueue and drain at count==DEPTH SHALL be impossible, because st_ready=0.
REQ-031 Simultaneous enqueue and drain at 0<count<DEPTH SHALL leave count unchanged.
REQ-032 empty SHALL equal (count == 0), registered-state derived.
REQ-033 Stores SHALL drain in strict FIFO order; no coalescing.

Reset
REQ-034 On rst_n low, at any time: count=0, head=tail=0, all valid bits cleared; pending stores are discarded.
REQ-035 During reset: st_ready=1, empty=1, mem_WE=0, ld_stall=0, ld_data=0; mem_A follows ld_addr.
REQ-036 The first enqueue SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-037 Store 0x10000<-0xAA with no loads -> next cycle mem_WE=1, mem_A=0x10000, mem_WD=0xAA; the cycle after, empty=1.
REQ-038 Stores 0x20<-0x11 then 0x20<-0x22, with ld_valid held high at 0x20 -> ld_data=0x22 (youngest) with no drains; 0x11 drains before 0x22 once loads stop.
REQ-039 Load ld_addr=0x30 with no matching entry and mem_RD=0x000000C3 -> ld_data=0x000000C3, ld_stall=0.
REQ-040 Four stores with ld_valid held high -> st_ready=0 at count 4; the next cycle ld_stall=1 with mem_WE=1 at the head address; st_ready returns to 1 the following cycle.
REQ-041 Six stores with wrap-around and loads interleaved -> memory writes occur in issue order and pointers wrap with no lost or duplicated store.
REQ-042 rst_n pulsed low asynchronously with 3 entries pending -> immediately empty=1, mem_WE=0; no pending store is ever written.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of byte stores placed between the memory
// stage and data memory. Stores drain to memory in idle cycles, and loads
// see the youngest matching buffered byte. When the buffer is full, the
// drain takes priority over a load.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int EXT_WIDTH  = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_valid,
  input  logic [EXT_WIDTH-1:0] st_addr,
  input  logic [EXT_WIDTH-1:0] st_data,
  output logic                 st_ready,
  input  logic                 ld_valid,
  input  logic [EXT_WIDTH-1:0] ld_addr,
  output logic [EXT_WIDTH-1:0] ld_data,
  output logic                 ld_stall,
  output logic [EXT_WIDTH-1:0] mem_A,
  output logic [EXT_WIDTH-1:0] mem_WD,
  output logic                 mem_WE,
  input  logic [EXT_WIDTH-1:0] mem_RD,
  output logic                 empty
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int PADW = EXT_WIDTH - DATA_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EXT_WIDTH-1:0]  ent_addr [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]      ent_vld;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;

  logic                  enq;
  logic                  drain;
  logic                  hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PW-1:0]         idx;
  logic                  unused_hi;

  // Only the low byte of the store data and of the memory read data is meaningful.
  assign unused_hi = ^{st_data[EXT_WIDTH-1:DATA_WIDTH], mem_RD[EXT_WIDTH-1:DATA_WIDTH]};

  assign st_ready = (count < FULL);
  assign enq      = st_valid && st_ready;
  // A load holds off draining unless the buffer is full.
  assign drain    = (count != '0) && (!ld_valid || (count == FULL));
  assign empty    = (count == '0);

  assign mem_WE   = drain;
  assign mem_A    = drain ? ent_addr[head] : ld_addr;
  assign mem_WD   = drain ? {{PADW{1'b0}}, ent_data[head]} : '0;
  assign ld_stall = ld_valid && drain;

  // Search the entries from oldest to youngest so that the last hit is the youngest one.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_vld[idx] && (ent_addr[idx] == ld_addr)) begin
        hit      = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  // Load result: forwarded byte or memory byte, and zero when no load is serviced.
  always_comb begin
    ld_data = '0;
    if (rst_n && ld_valid && !drain) begin
      ld_data = hit ? {{PADW{1'b0}}, fwd_data} : {{PADW{1'b0}}, mem_RD[DATA_WIDTH-1:0]};
    end
  end

  // Pointer, occupancy and valid-bit bookkeeping; reset discards pending stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (enq) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (drain) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (enq && !drain) begin
        count <= count + CW'(1);
      end else if (drain && !enq) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry payload; it is only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed per-cycle vectors. Expected memory
// writes and load responses are queued by the stimulus and popped by a
// negedge monitor.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;
  logic        empty;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] wr_q[$];
  logic [32:0] ld_q[$];

  store_buffer #(.DEPTH(4), .EXT_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write and every load response is matched against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_WE === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got A=%0h WD=%0h expected no write", mem_A, mem_WD);
        end else begin
          chk("mem_write", {mem_A, mem_WD}, wr_q.pop_front());
        end
      end
      if (ld_valid === 1'b1) begin
        if (ld_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_load: got %0h expected nothing", {ld_stall, ld_data});
        end else begin
          chk("load_resp", 64'({ld_stall, ld_data}), 64'(ld_q.pop_front()));
        end
      end
    end
  end

  // One clock cycle of stimulus with its hand-computed expectations.
  task automatic step(input string tag, input logic stv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic ldv, input logic [31:0] la, input logic [31:0] rd,
                      input logic e_rdy, input logic e_we, input logic e_empty,
                      input logic e_stall, input logic [31:0] e_ld);
    st_valid = stv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = ldv;
    ld_addr  = la;
    mem_RD   = rd;
    if (ldv) ld_q.push_back({e_stall, e_ld});
    if (stv && e_rdy) wr_q.push_back({sa, 24'h0, sd[7:0]});
    @(negedge clk);
    chk({tag, ".st_ready"}, 64'(st_ready), 64'(e_rdy));
    chk({tag, ".mem_WE"}, 64'(mem_WE), 64'(e_we));
    chk({tag, ".empty"}, 64'(empty), 64'(e_empty));
    if (!e_we) chk({tag, ".mem_bus"}, {mem_A, mem_WD}, {la, 32'h0});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic e_we, input logic e_empty);
    step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, e_we, e_empty, 1'b0, 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    st_valid = 1'b0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    ld_valid = 1'b1;
    ld_addr  = 32'h44;
    mem_RD   = 32'hFF;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.st_ready", 64'(st_ready), 64'd1);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.mem_WE", 64'(mem_WE), 64'd0);
    chk("rst.ld_stall", 64'(ld_stall), 64'd0);
    chk("rst.ld_data", 64'(ld_data), 64'd0);
    chk("rst.mem_A", 64'(mem_A), 64'h44);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single store, drains the next cycle.
    step("t1a", 1, 32'h10000, 32'hAA, 0, 0, 0, 1, 0, 1, 0, 0);
    idle("t1b", 1, 0);
    idle("t1c", 0, 1);

    // Two stores to one address: youngest forwarded, FIFO drain order.
    step("t2a", 1, 32'h20, 32'h11, 1, 32'h20, 32'h99, 1, 0, 1, 0, 32'h99);
    step("t2b", 1, 32'h20, 32'h22, 1, 32'h20, 32'h99, 1, 0, 0, 0, 32'h11);
    step("t2c", 0, 0, 0, 1, 32'h20, 32'h99, 1, 0, 0, 0, 32'h22);
    idle("t2d", 1, 0);
    idle("t2e", 1, 0);
    idle("t2f", 0, 1);

    // Load miss returns the zero-extended memory byte.
    step("t3a", 0, 0, 0, 1, 32'h30, 32'hC3, 1, 0, 1, 0, 32'hC3);
    step("t3b", 0, 0, 0, 1, 32'h30, 32'h5A5A5AC3, 1, 0, 1, 0, 32'hC3);

    // Fill with loads held: full buffer stalls the load and drains.
    step("t4a", 1, 32'h100, 32'h01, 1, 32'h40, 32'h77, 1, 0, 1, 0, 32'h77);
    step("t4b", 1, 32'h101, 32'h02, 1, 32'h40, 32'h77, 1, 0, 0, 0, 32'h77);
    step("t4c", 1, 32'h102, 32'h03, 1, 32'h40, 32'h77, 1, 0, 0, 0, 32'h77);
    step("t4d", 1, 32'h103, 32'h04, 1, 32'h40, 32'h77, 1, 0, 0, 0, 32'h77);
    step("t4e", 1, 32'h104, 32'h05, 1, 32'h40, 32'h77, 0, 1, 0, 1, 32'h0);
    step("t4f", 1, 32'h104, 32'h05, 1, 32'h40, 32'h77, 1, 0, 0, 0, 32'h77);
    step("t4g", 0, 0, 0, 1, 32'h103, 32'h77, 0, 1, 0, 1, 32'h0);
    step("t4h", 0, 0, 0, 1, 32'h103, 32'h77, 1, 0, 0, 0, 32'h04);
    idle("t4i", 1, 0);
    idle("t4j", 1, 0);
    idle("t4k", 1, 0);
    idle("t4l", 0, 1);

    // Six stores with wrap-around and interleaved loads.
    step("t5a", 1, 32'h200, 32'hA0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("t5b", 1, 32'h201, 32'hA1, 1, 32'h200, 32'h0, 1, 0, 0, 0, 32'hA0);
    step("t5c", 1, 32'h202, 32'hA2, 0, 0, 0, 1, 1, 0, 0, 0);
    step("t5d", 1, 32'h203, 32'hA3, 1, 32'h202, 32'h0, 1, 0, 0, 0, 32'hA2);
    step("t5e", 1, 32'h204, 32'hA4, 1, 32'h200, 32'h5E, 1, 0, 0, 0, 32'h5E);
    step("t5f", 1, 32'h205, 32'hA5, 1, 32'h205, 32'h11, 0, 1, 0, 1, 32'h0);
    step("t5g", 1, 32'h205, 32'hA5, 0, 0, 0, 1, 1, 0, 0, 0);
    step("t5h", 0, 0, 0, 1, 32'h205, 32'h11, 1, 0, 0, 0, 32'hA5);
    idle("t5i", 1, 0);
    idle("t5j", 1, 0);
    idle("t5k", 1, 0);
    idle("t5l", 0, 1);

    // Three pending stores discarded by an asynchronous reset.
    step("t6a", 1, 32'h300, 32'hB0, 1, 32'h999, 32'h0, 1, 0, 1, 0, 32'h0);
    step("t6b", 1, 32'h301, 32'hB1, 1, 32'h999, 32'h0, 1, 0, 0, 0, 32'h0);
    step("t6c", 1, 32'h302, 32'hB2, 1, 32'h999, 32'h0, 1, 0, 0, 0, 32'h0);
    st_valid = 1'b0;
    mem_RD   = 32'h42;
    chk("t6.pending", 64'(empty), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    wr_q.delete();
    chk("t6.empty", 64'(empty), 64'd1);
    chk("t6.mem_WE", 64'(mem_WE), 64'd0);
    chk("t6.st_ready", 64'(st_ready), 64'd1);
    chk("t6.ld_stall", 64'(ld_stall), 64'd0);
    chk("t6.ld_data", 64'(ld_data), 64'd0);
    chk("t6.mem_A", 64'(mem_A), 64'h999);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle("t6d", 0, 1);
    idle("t6e", 0, 1);
    idle("t6f", 0, 1);

    chk("end.wr_q", 64'(wr_q.size()), 64'd0);
    chk("end.ld_q", 64'(ld_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
